// File: rtl/wb_pkg.sv
// Shared Wishbone command-controller definitions.
//
// Contents:
//   wb_status_e     - 2-bit outcome code returned with every response
//   wb_cmd_state_e  - controller FSM state encoding
//   RetryCntWidth   - width of the retry counter (MAX_RETRIES range 0..15)
//   TimeoutCntWidth - width of the optional wait-state timeout counter

package wb_pkg;

    localparam int unsigned RetryCntWidth   = 4;
    localparam int unsigned TimeoutCntWidth = 16;

    typedef enum logic [1:0] {
        StatusOk      = 2'd0,
        StatusErr     = 2'd1,
        StatusRty     = 2'd2,
        StatusTimeout = 2'd3
    } wb_status_e;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StBackoff,
        StResp
    } wb_cmd_state_e;

endpackage

// File: rtl/wb_classic_cmd_controller.sv
// Wishbone B4 classic-cycle controller.
//
// Converts a valid/ready command stream into single read/write bus cycles and
// reports each cycle's outcome on a valid/ready response stream. Retries on
// rty_i (up to MAX_RETRIES reissues, each preceded by one idle bus cycle) and,
// when the WB_CMD_TIMEOUT_EN macro is defined, abandons a cycle after
// TIMEOUT_CYCLES wait states.
//
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o - command handshake; cmd_we_i, cmd_dat_i payload
//   rsp_valid_o/rsp_ready_i - response handshake; rsp_dat_o, rsp_status_o payload
//   cyc_o, stb_o, we_o      - Wishbone request, dat_o write data
//   ack_i, err_i, rty_i     - Wishbone terminations, dat_i read data
//
// Configuration macro: WB_CMD_TIMEOUT_EN (undefined: wait indefinitely).

module wb_classic_cmd_controller
    import wb_pkg::*;
#(
    parameter int unsigned DAT_WIDTH      = 8,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [DAT_WIDTH-1:0] cmd_dat_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]           rsp_status_o,

    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    input  logic [DAT_WIDTH-1:0] dat_i
);

    // Elaboration-time parameter range checks.
    if (MAX_RETRIES > 15) begin : gen_bad_max_retries
        $error("MAX_RETRIES must be in 0..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    localparam logic [RetryCntWidth-1:0] MaxRetries = RetryCntWidth'(MAX_RETRIES);

    wb_cmd_state_e              state_q, state_d;
    logic                       cyc_q, cyc_d;
    logic                       we_q, we_d;
    logic [DAT_WIDTH-1:0]       dat_q, dat_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [DAT_WIDTH-1:0]       rsp_dat_q, rsp_dat_d;
    wb_status_e                 rsp_status_q, rsp_status_d;
    logic [RetryCntWidth-1:0]   retry_cnt_q, retry_cnt_d;

`ifdef WB_CMD_TIMEOUT_EN
    // Terminal count is one less than the limit: the counter starts at 0 in the
    // first bus cycle, so the request is held for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TimeoutCntWidth-1:0] TimeoutLast =
        TimeoutCntWidth'(TIMEOUT_CYCLES - 1);
    logic [TimeoutCntWidth-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Only output not registered; gated by reset so nothing is accepted while
    // the controller is held in reset.
    assign cmd_ready_o = (state_q == StIdle) && !rst_i;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        dat_d        = dat_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        retry_cnt_d  = retry_cnt_q;
`ifdef WB_CMD_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    we_d        = cmd_we_i;
                    dat_d       = cmd_dat_i;
                    retry_cnt_d = '0;
                    cyc_d       = 1'b1;
                    state_d     = StBus;
`ifdef WB_CMD_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end

            StBus: begin
                // Priority: err > rty > ack > timeout.
                if (err_i) begin
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = StatusErr;
                    rsp_dat_d    = '0;
                    state_d      = StResp;
                end else if (rty_i) begin
                    cyc_d = 1'b0;
                    if (retry_cnt_q < MaxRetries) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = StBackoff;
                    end else begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = StatusRty;
                        rsp_dat_d    = '0;
                        state_d      = StResp;
                    end
                end else if (ack_i) begin
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = StatusOk;
                    rsp_dat_d    = we_q ? '0 : dat_i;
                    state_d      = StResp;
                end
`ifdef WB_CMD_TIMEOUT_EN
                else if (tmo_cnt_q == TimeoutLast) begin
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = StatusTimeout;
                    rsp_dat_d    = '0;
                    state_d      = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            StBackoff: begin
                // One idle bus cycle, then reissue the latched request.
                cyc_d   = 1'b1;
                state_d = StBus;
`ifdef WB_CMD_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            dat_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= StatusOk;
            retry_cnt_q  <= '0;
`ifdef WB_CMD_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            dat_q        <= dat_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            retry_cnt_q  <= retry_cnt_d;
`ifdef WB_CMD_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    // Single-beat classic cycles: stb always follows cyc.
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = we_q;
    assign dat_o        = dat_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;

endmodule
